// File: rtl/bram_rd_sched.sv
// BRAM read sequencer: streams len 64-bit words from base_addr as 32-bit beats, upper half first.
// Optional BRAM_RD_ABORT_EN adds an abort input that terminates a transfer early.
module bram_rd_sched #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [63:0]       bram_dout,
    output logic [31:0]       m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
`ifdef BRAM_RD_ABORT_EN
    input  logic              abort,
`endif
    output logic              m_tlast
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HI    = 3'd3;
    localparam logic [2:0] S_LO    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  words_left;
    logic [63:0]       hold;
    logic [63:0]       pf_reg;
    logic              pf_valid;
    logic              pf_pending;

    logic hs;
    logic last_word;
    logic prefetch;
    logic abort_req;

    always_comb begin
        m_tvalid  = (state == S_HI) || (state == S_LO);
        hs        = m_tvalid && m_tready;
        last_word = (words_left == LEN_W'(1));
        // Next word is requested as the upper half leaves, so it lands in time for the next HI.
        prefetch  = (state == S_HI) && hs && !last_word;
        bram_en   = (state == S_FETCH) || prefetch;
        bram_addr = bram_en ? cur_addr : '0;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        m_tlast   = (state == S_LO) && last_word;
        if (state == S_HI)
            m_tdata = hold[63:32];
        else if (state == S_LO)
            m_tdata = hold[31:0];
        else
            m_tdata = '0;
`ifdef BRAM_RD_ABORT_EN
        abort_req = abort && (state == S_FETCH || state == S_WAIT ||
                              state == S_HI || state == S_LO);
`else
        abort_req = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cur_addr   <= '0;
            words_left <= '0;
            hold       <= '0;
            pf_reg     <= '0;
            pf_valid   <= 1'b0;
            pf_pending <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_addr   <= base_addr;
                        words_left <= len;
                        pf_valid   <= 1'b0;
                        pf_pending <= 1'b0;
                        state      <= (len != '0) ? S_FETCH : S_DONE;
                    end
                end
                S_FETCH: begin
                    cur_addr <= cur_addr + ADDR_W'(1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    hold  <= bram_dout;
                    state <= S_HI;
                end
                S_HI: begin
                    pf_pending <= prefetch;
                    if (prefetch)
                        cur_addr <= cur_addr + ADDR_W'(1);
                    if (hs)
                        state <= S_LO;
                end
                S_LO: begin
                    pf_pending <= 1'b0;
                    // BRAM output is only valid for one cycle; park it if the consumer stalls.
                    if (pf_pending) begin
                        pf_reg   <= bram_dout;
                        pf_valid <= 1'b1;
                    end
                    if (hs) begin
                        if (last_word) begin
                            state <= S_DONE;
                        end else begin
                            hold       <= pf_valid ? pf_reg : bram_dout;
                            pf_valid   <= 1'b0;
                            words_left <= words_left - LEN_W'(1);
                            state      <= S_HI;
                        end
                    end
                end
                S_DONE: begin
                    pf_valid   <= 1'b0;
                    pf_pending <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (abort_req) begin
                pf_valid   <= 1'b0;
                pf_pending <= 1'b0;
                state      <= S_DONE;
            end
        end
    end

endmodule

// File: tb/tb_bram_rd_sched.sv
// Directed bench for bram_rd_sched: table of transfers checked against a BRAM model,
// plus hand-written reset, busy-start and (with BRAM_RD_ABORT_EN) abort sequences.
module tb_bram_rd_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  len;
    logic        busy;
    logic        done;
    logic        bram_en;
    logic [9:0]  bram_addr;
    logic [63:0] bram_dout;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
`ifdef BRAM_RD_ABORT_EN
    logic        abort;
`endif

    logic [63:0] mem [0:1023];

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [9:0] base;
        logic [9:0] ln;
        int         mode;      // bit0: random ready, bit1: start pulse while busy
        int         exp_beats;
        int         exp_reads;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    // Latency-1 BRAM; output is garbage whenever the previous cycle had no read.
    always @(posedge clk)
        bram_dout <= bram_en ? mem[bram_addr] : 64'hDEAD_BEEF_0BAD_F00D;

    bram_rd_sched #(.ADDR_W(10), .LEN_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bram_en   (bram_en),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
`ifdef BRAM_RD_ABORT_EN
        .abort     (abort),
`endif
        .m_tlast   (m_tlast)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic run_xfer(input vec_t v);
        int          beats = 0;
        int          reads = 0;
        int          dones = 0;
        int          first_c = -1;
        int          last_c = -1;
        int          done_c = -1;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        logic [9:0]  wa;
        logic [63:0] w;
        logic [31:0] exp_d;
        @(negedge clk);
        start = 1'b1; base_addr = v.base; len = v.ln;
        @(negedge clk);
        start = 1'b0; base_addr = 10'h155; len = 10'd0;
        chk("busy_after_start", 64'(busy), 64'(1));
        for (int c = 0; c < 300; c++) begin
            if (c > 0) @(negedge clk);
            m_tready = ((v.mode & 1) != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            start = ((v.mode & 2) != 0) && (c == 3);
            if (start) begin
                base_addr = 10'h200; len = 10'd7;
            end
            #1;
            if (bram_en) begin
                wa = v.base + 10'(reads);
                chk("rd_addr", 64'(bram_addr), 64'(wa));
                reads++;
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(m_tvalid), 64'(1));
                chk("stall_data", 64'(m_tdata), 64'(prev_data));
                chk("stall_last", 64'(m_tlast), 64'(prev_last));
            end
            if (!m_tvalid)
                chk("idle_data_zero", 64'(m_tdata), 64'(0));
            if (m_tvalid && m_tready) begin
                wa    = v.base + 10'(beats / 2);
                w     = mem[wa];
                exp_d = (beats % 2 == 0) ? w[63:32] : w[31:0];
                chk("beat_data", 64'(m_tdata), 64'(exp_d));
                chk("beat_last", 64'(m_tlast), 64'(beats == 2 * int'(v.ln) - 1));
                if (first_c < 0) first_c = c;
                last_c = c;
                beats++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            if (done) begin
                dones++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c >= done_c + 3) break;
        end
        start = 1'b0;
        chk("beat_count", 64'(beats), 64'(v.exp_beats));
        chk("read_count", 64'(reads), 64'(v.exp_reads));
        chk("done_pulses", 64'(dones), 64'(1));
        chk("busy_end", 64'(busy), 64'(0));
        if (v.exp_beats > 0)
            chk("done_latency", 64'(done_c), 64'(last_c + 1));
        if (v.exp_beats > 0 && (v.mode & 1) == 0)
            chk("back_to_back", 64'(last_c - first_c), 64'(v.exp_beats - 1));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; m_tready = 1'b0;
        base_addr = '0; len = '0;
`ifdef BRAM_RD_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < 1024; i++)
            mem[i] = {16'hA5A5 ^ 16'(i), 16'(i), 16'h5A00 + 16'(i), ~16'(i)};
        mem[10'h010] = 64'hAAAA_BBBB_CCCC_DDDD;

        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_bram_en", 64'(bram_en), 64'(0));
        chk("rst_bram_addr", 64'(bram_addr), 64'(0));
        chk("rst_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_tdata", 64'(m_tdata), 64'(0));
        chk("rst_tlast", 64'(m_tlast), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{10'h010, 10'd1, 0, 2, 1};
        vecs[1] = '{10'h010, 10'd4, 0, 8, 4};
        vecs[2] = '{10'h020, 10'd3, 1, 6, 3};
        vecs[3] = '{10'h3FE, 10'd3, 0, 6, 3};
        vecs[4] = '{10'h000, 10'd0, 0, 0, 0};
        vecs[5] = '{10'h100, 10'd5, 3, 10, 5};
        vecs[6] = '{10'h3FF, 10'd2, 1, 4, 2};
        for (int i = 0; i < 7; i++)
            run_xfer(vecs[i]);

        // Asynchronous reset while stalled on a lower-half beat.
        @(negedge clk);
        start = 1'b1; base_addr = 10'h040; len = 10'd2;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            m_tready = 1'b1;
            #1;
            if (m_tvalid) break;
            @(negedge clk);
        end
        @(negedge clk);
        m_tready = 1'b0;
        #1;
        chk("lo_before_reset", 64'(m_tdata), 64'(mem[10'h040][31:0]));
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_tvalid", 64'(m_tvalid), 64'(0));
        chk("async_rst_bram_en", 64'(bram_en), 64'(0));
        chk("async_rst_busy", 64'(busy), 64'(0));
        chk("async_rst_tdata", 64'(m_tdata), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer('{10'h030, 10'd1, 0, 2, 1});

`ifdef BRAM_RD_ABORT_EN
        begin
            int beats = 0;
            int dones = 0;
            bit found = 1'b0;
            bit saw_last = 1'b0;
            @(negedge clk);
            start = 1'b1; base_addr = 10'h050; len = 10'd3;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 40; c++) begin
                m_tready = 1'b1;
                #1;
                if (m_tvalid && beats == 2) begin
                    found = 1'b1;
                    break;
                end
                if (m_tvalid && m_tready) begin
                    if (m_tlast) saw_last = 1'b1;
                    beats++;
                end
                @(negedge clk);
            end
            chk("abort_reached_word2", 64'(found), 64'(1));
            chk("abort_hi_data", 64'(m_tdata), 64'(mem[10'h051][63:32]));
            m_tready = 1'b0;
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            #1;
            chk("abort_tvalid", 64'(m_tvalid), 64'(0));
            chk("abort_bram_en", 64'(bram_en), 64'(0));
            chk("abort_tlast", 64'(m_tlast), 64'(0));
            for (int c = 0; c < 4; c++) begin
                if (done) dones++;
                if (m_tlast) saw_last = 1'b1;
                @(negedge clk);
                #1;
            end
            chk("abort_single_done", 64'(dones), 64'(1));
            chk("abort_no_tlast", 64'(saw_last), 64'(0));
            chk("abort_busy_end", 64'(busy), 64'(0));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
